mem_readin_demux: RTL

Receive-side counterpart of the projection readout stream. Accepts the 52-bit tagged word stream produced by memory readout, checks each word's BX tag, and routes the 45-bit payload to one of 12 destination memories, packing words from address 0 upward. Writes use a ping-pong page per event. At each event boundary the block reports per-memory item counts, overflow flags and a drop count. It sits between the inter-board link FIFO output and the downstream memories read by `mem_readout_top`.

---
 rtl/mem_readin_demux.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_readin_demux.sv
// mem_readin_demux
// Receive side of the projection readout stream. Each 52-bit word carries a
// BX tag [51:49], a destination memory index [48:45] and a payload [44:0].
// Accepted payloads are packed from slot 0 upward into one of NMEM memories,
// using a ping-pong page that flips at every event boundary. When an event
// closes, the per-memory item counts, overflow flags and drop count are
// published with a one-cycle nitems_valid pulse.
// Optional feature macro: MEM_READIN_BX_CHECK_EN (drop words whose BX tag
// differs from the BX of the open event).
module mem_readin_demux #(
   parameter int NMEM   = 12,
   parameter int DATA_W = 45,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       new_event,
   input  logic [2:0]                 BX,
   input  logic [51:0]                din,
   input  logic                       din_valid,
   output logic [NMEM-1:0]            wr_en,
   output logic [ADDR_W:0]            wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic [NMEM*(ADDR_W+1)-1:0] nitems,
   output logic                       nitems_valid,
   output logic                       nitems_page,
   output logic [NMEM-1:0]            overflow,
   output logic [7:0]                 drop_cnt
);

   // Counters are one bit wider than a slot address so DEPTH itself fits.
   localparam int CW = ADDR_W + 1;
   localparam logic [4:0]    NMEM_L  = 5'(NMEM);
   localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state;
   logic              r_page;
   logic [2:0]        r_cur_bx;
   logic [CW-1:0]     r_cnt [NMEM];
   logic [NMEM-1:0]   r_ovf;
   logic [7:0]        r_drop;

   logic [3:0]        w_idx;
   logic              w_idx_ok;
   logic              w_bx_ok;
   logic [NMEM-1:0]   w_onehot;
   logic [CW-1:0]     w_sel_cnt;
   logic              w_full;
   logic              w_run_word;
   logic              w_acc;
   logic              w_rej;
   logic [NMEM-1:0]   w_ovf_hit;
   logic [CW-1:0]     w_cnt_nxt [NMEM];
   logic [NMEM-1:0]   w_ovf_nxt;
   logic [7:0]        w_drop_nxt;

   // Drop counter increments but sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_idx      = din[48:45];
   assign w_idx_ok   = {1'b0, w_idx} < NMEM_L;
   assign w_run_word = (r_state == RUN) && din_valid;

`ifdef MEM_READIN_BX_CHECK_EN
   assign w_bx_ok = (din[51:49] == r_cur_bx);
`else
   // Tag and event BX are carried but deliberately not compared in this build.
   logic w_unused_tag;
   assign w_unused_tag = ^{din[51:49], r_cur_bx};
   assign w_bx_ok      = 1'b1;
`endif

   // Decode the destination, fetch its fill level and compute next-state counts.
   always_comb begin
      w_onehot  = '0;
      w_sel_cnt = '0;
      for (int k = 0; k < NMEM; k++) begin
         if (w_idx == 4'(k)) begin
            w_onehot[k] = 1'b1;
            w_sel_cnt   = r_cnt[k];
         end
      end
      w_full    = (w_sel_cnt == DEPTH_L);
      w_acc     = w_run_word && w_idx_ok && w_bx_ok && !w_full;
      w_rej     = w_run_word && !w_acc;
      w_ovf_hit = (w_run_word && w_idx_ok && w_bx_ok && w_full) ? w_onehot : '0;
      for (int k = 0; k < NMEM; k++) begin
         w_cnt_nxt[k] = r_cnt[k] + {{(CW-1){1'b0}}, (w_acc && w_onehot[k])};
      end
      w_ovf_nxt  = r_ovf | w_ovf_hit;
      w_drop_nxt = w_rej ? sat_inc8(r_drop) : r_drop;
   end

   // Registered write port: strobe, {page, slot} address and payload one cycle after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= w_acc ? w_onehot : '0;
         if (w_acc) begin
            wr_addr <= {r_page, w_sel_cnt[ADDR_W-1:0]};
            wr_data <= din[DATA_W-1:0];
         end
      end
   end

   // Event FSM: opens events, tracks per-event counters, publishes the snapshot on close.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_page       <= 1'b0;
         r_cur_bx     <= '0;
         r_ovf        <= '0;
         r_drop       <= '0;
         nitems       <= '0;
         nitems_valid <= 1'b0;
         nitems_page  <= 1'b0;
         overflow     <= '0;
         drop_cnt     <= '0;
         for (int k = 0; k < NMEM; k++) r_cnt[k] <= '0;
      end else begin
         nitems_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (new_event) begin
                  r_state  <= RUN;
                  r_cur_bx <= BX;
                  r_page   <= 1'b0;
                  r_ovf    <= '0;
                  r_drop   <= '0;
                  for (int k = 0; k < NMEM; k++) r_cnt[k] <= '0;
               end
            end
            RUN: begin
               if (new_event) begin
                  // A word arriving with the strobe is already folded into the *_nxt values.
                  for (int k = 0; k < NMEM; k++) nitems[k*CW +: CW] <= w_cnt_nxt[k];
                  overflow     <= w_ovf_nxt;
                  drop_cnt     <= w_drop_nxt;
                  nitems_page  <= r_page;
                  nitems_valid <= 1'b1;
                  r_page       <= ~r_page;
                  r_cur_bx     <= BX;
                  r_ovf        <= '0;
                  r_drop       <= '0;
                  for (int k = 0; k < NMEM; k++) r_cnt[k] <= '0;
               end else begin
                  for (int k = 0; k < NMEM; k++) r_cnt[k] <= w_cnt_nxt[k];
                  r_ovf  <= w_ovf_nxt;
                  r_drop <= w_drop_nxt;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
